uart_rx_frontend: RTL and testbench

Oversampling UART receiver that deserialises the serial RX_IN line into parallel bytes in the RX clock domain. It runs on the RX clock at Prescale × baud. It produces the parallel data and data-valid pulse consumed by the downstream data synchroniser and system controller. It also flags parity and stop-bit errors.

---
 rtl/uart_rx_frontend.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver: start/data/parity/stop deserialiser with 2-of-3 majority
// sampling around mid-bit and single-cycle data_valid / PAR_ERR / STP_ERR pulses.
module uart_rx_frontend #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);
    localparam logic [BCW-1:0]            LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic [BCW-1:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_samp0;
    logic                      r_samp1;
    logic                      r_par_bad;
    logic                      r_stop_bit;

    logic [PRESCALE_WIDTH-1:0] w_half;
    logic                      w_last;
    logic                      w_s0;
    logic                      w_s1;
    logic                      w_dec;
    logic                      w_maj;
    logic                      w_start_det;
    logic                      w_last_bit;
    logic                      w_exp_par;
    logic                      w_frame_done;
    logic                      w_ok;

    // Edge-position decodes, all relative to the prescale latched at start detection.
    assign w_half       = r_presc >> 1;
    assign w_last       = (r_edge_cnt == (r_presc - ONE));
    assign w_s0         = (r_state != S_IDLE) && (r_edge_cnt == (w_half - ONE));
    assign w_s1         = (r_state != S_IDLE) && (r_edge_cnt == w_half);
    assign w_dec        = (r_state != S_IDLE) && (r_edge_cnt == (w_half + ONE));
    assign w_maj        = (r_samp0 & r_samp1) | (r_samp0 & RX_IN) | (r_samp1 & RX_IN);
    assign w_start_det  = (r_state == S_IDLE) && !RX_IN;
    assign w_last_bit   = (r_bit_cnt == LAST_BIT);
    assign w_exp_par    = (^r_shift) ^ r_par_typ;
    assign w_frame_done = (r_state == S_STOP) && w_last;
    assign w_ok         = r_stop_bit && !(r_par_en && r_par_bad);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!RX_IN) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_dec && w_maj) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last && w_last_bit) begin
                    w_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_last) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Detection cycle is edge 0, so the counter enters START already at 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_edge_cnt <= w_start_det ? ONE : '0;
        end else if ((w_next == S_IDLE) || w_last) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt <= '0;
        end else if (r_state == S_START) begin
            r_bit_cnt <= '0;
        end else if ((r_state == S_DATA) && w_last && !w_last_bit) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc   <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_start_det) begin
            r_presc   <= Prescale;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_bad  <= 1'b0;
            r_stop_bit <= 1'b1;
        end else begin
            if (w_start_det) begin
                r_par_bad <= 1'b0;
            end else if ((r_state == S_PARITY) && w_dec) begin
                r_par_bad <= (w_maj != w_exp_par);
            end
            if ((r_state == S_STOP) && w_dec) begin
                r_stop_bit <= w_maj;
            end
        end
    end

    // Sample registers and shift register carry no reset; they are always rewritten before use.
    always_ff @(posedge CLK) begin
        if (w_s0) begin
            r_samp0 <= RX_IN;
        end
        if (w_s1) begin
            r_samp1 <= RX_IN;
        end
        if ((r_state == S_DATA) && w_dec) begin
            r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            if (w_frame_done) begin
                STP_ERR <= !r_stop_bit;
                PAR_ERR <= r_par_en && r_par_bad;
                if (w_ok) begin
                    data_valid <= 1'b1;
                    P_DATA     <= r_shift;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: frames are driven bit-by-bit at the oversampling
// rate and outputs are checked at the expected pulse cycle.
module tb_uart_rx_frontend;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       PAR_ERR;
    logic       STP_ERR;

    int errors;
    int checks;

    uart_rx_frontend #(
        .DATA_WIDTH(8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .Prescale(Prescale),
        .P_DATA(P_DATA),
        .data_valid(data_valid),
        .PAR_ERR(PAR_ERR),
        .STP_ERR(STP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives one frame starting in the current cycle (cycle 0). Returns at cycle N*P + 1ns.
    // early counts output pulses seen before the final cycle. abit/aedge assert RST and return.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input int p,
                              input logic flip, input logic stopv, input int gbit, input int gedge,
                              input int tbit, input int abit, input int aedge, output int early);
        logic [11:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        if (pe) begin
            bits[9]  = (^d) ^ pt ^ flip;
            bits[10] = stopv;
            nb = 11;
        end else begin
            bits[9] = stopv;
            nb = 10;
        end
        PAR_EN   = pe;
        PAR_TYP  = pt;
        Prescale = 6'(p);
        early    = 0;
        for (int b = 0; b < nb; b++) begin
            if (b == tbit) PAR_TYP = ~PAR_TYP;
            for (int e = 0; e < p; e++) begin
                if (b == abit && e == aedge) begin
                    RST = 1'b0;
                    #1;
                    return;
                end
                RX_IN = (b == gbit && e == gedge) ? ~bits[b] : bits[b];
                @(posedge CLK);
                #1;
                if (!(b == nb - 1 && e == p - 1))
                    early += int'(data_valid | PAR_ERR | STP_ERR);
            end
        end
        RX_IN   = 1'b1;
        PAR_TYP = pt;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        Prescale = 6'd16;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata got=%h exp=00", P_DATA); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
        checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL reset_parerr got=%b exp=0", PAR_ERR); end
        checks++; if (STP_ERR !== 1'b0) begin errors++; $display("FAIL reset_stperr got=%b exp=0", STP_ERR); end
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_parity_ok();
        int early;
        send_frame(8'hA5, 1'b1, 1'b0, 16, 1'b0, 1'b1, -1, -1, -1, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL t1_early got=%0d exp=0", early); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t1_dv@176 got=%b exp=1", data_valid); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL t1_pdata got=%h exp=a5", P_DATA); end
        checks++; if ({PAR_ERR, STP_ERR} !== 2'b00) begin errors++; $display("FAIL t1_errs got=%b exp=00", {PAR_ERR, STP_ERR}); end
        @(posedge CLK);
        #1;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t1_dv_onecycle got=%b exp=0", data_valid); end
    endtask

    task automatic test_parity_err();
        int early;
        send_frame(8'h01, 1'b1, 1'b1, 16, 1'b1, 1'b1, -1, -1, -1, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL t2_early got=%0d exp=0", early); end
        checks++; if (PAR_ERR !== 1'b1) begin errors++; $display("FAIL t2_parerr@176 got=%b exp=1", PAR_ERR); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t2_dv got=%b exp=0", data_valid); end
        checks++; if (STP_ERR !== 1'b0) begin errors++; $display("FAIL t2_stperr got=%b exp=0", STP_ERR); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL t2_pdata_held got=%h exp=a5", P_DATA); end
        @(posedge CLK);
        #1;
        checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL t2_parerr_onecycle got=%b exp=0", PAR_ERR); end
    endtask

    task automatic test_stop_err();
        int early;
        send_frame(8'h3C, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1, -1, -1, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL t3a_early got=%0d exp=0", early); end
        checks++; if (STP_ERR !== 1'b1) begin errors++; $display("FAIL t3a_stperr@80 got=%b exp=1", STP_ERR); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t3a_dv got=%b exp=0", data_valid); end
        checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL t3a_parerr got=%b exp=0", PAR_ERR); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL t3a_pdata_held got=%h exp=a5", P_DATA); end
        repeat (3) @(posedge CLK);
        #1;
        send_frame(8'h3C, 1'b0, 1'b0, 8, 1'b0, 1'b1, -1, -1, -1, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL t3b_early got=%0d exp=0", early); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t3b_dv@80 got=%b exp=1", data_valid); end
        checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL t3b_pdata got=%h exp=3c", P_DATA); end
        checks++; if (STP_ERR !== 1'b0) begin errors++; $display("FAIL t3b_stperr got=%b exp=0", STP_ERR); end
    endtask

    task automatic test_start_glitch();
        int early;
        int pulses;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        Prescale = 6'd16;
        pulses = 0;
        RX_IN = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
        repeat (12) begin
            @(posedge CLK);
            #1;
            pulses += int'(data_valid | PAR_ERR | STP_ERR);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL t4_glitch_pulses got=%0d exp=0", pulses); end
        send_frame(8'h5A, 1'b1, 1'b0, 16, 1'b0, 1'b1, -1, -1, -1, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL t4_early got=%0d exp=0", early); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t4_dv got=%b exp=1", data_valid); end
        checks++; if (P_DATA !== 8'h5A) begin errors++; $display("FAIL t4_pdata got=%h exp=5a", P_DATA); end
        checks++; if ({PAR_ERR, STP_ERR} !== 2'b00) begin errors++; $display("FAIL t4_errs got=%b exp=00", {PAR_ERR, STP_ERR}); end
    endtask

    task automatic test_data_glitch();
        int early;
        send_frame(8'hFF, 1'b1, 1'b0, 16, 1'b0, 1'b1, 4, 8, -1, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL t5_early got=%0d exp=0", early); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t5_dv got=%b exp=1", data_valid); end
        checks++; if (P_DATA !== 8'hFF) begin errors++; $display("FAIL t5_pdata got=%h exp=ff", P_DATA); end
        checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL t5_parerr got=%b exp=0", PAR_ERR); end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back();
        int early;
        send_frame(8'h11, 1'b1, 1'b0, 16, 1'b0, 1'b1, -1, -1, -1, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL b2b1_early got=%0d exp=0", early); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b1_dv got=%b exp=1", data_valid); end
        checks++; if (P_DATA !== 8'h11) begin errors++; $display("FAIL b2b1_pdata got=%h exp=11", P_DATA); end
        send_frame(8'h22, 1'b1, 1'b0, 16, 1'b0, 1'b1, -1, -1, -1, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL b2b2_early got=%0d exp=0", early); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b2_dv@+176 got=%b exp=1", data_valid); end
        checks++; if (P_DATA !== 8'h22) begin errors++; $display("FAIL b2b2_pdata got=%h exp=22", P_DATA); end
        checks++; if ({PAR_ERR, STP_ERR} !== 2'b00) begin errors++; $display("FAIL b2b2_errs got=%b exp=00", {PAR_ERR, STP_ERR}); end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_midframe();
        int early;
        send_frame(8'h96, 1'b1, 1'b0, 16, 1'b0, 1'b1, -1, -1, -1, 5, 5, early);
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL t6_rst_pdata got=%h exp=00", P_DATA); end
        checks++; if ({data_valid, PAR_ERR, STP_ERR} !== 3'b000) begin errors++; $display("FAIL t6_rst_flags got=%b exp=000", {data_valid, PAR_ERR, STP_ERR}); end
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        send_frame(8'hC3, 1'b1, 1'b0, 16, 1'b0, 1'b1, -1, -1, 4, -1, -1, early);
        checks++; if (early !== 0) begin errors++; $display("FAIL t6_early got=%0d exp=0", early); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t6_dv got=%b exp=1", data_valid); end
        checks++; if (P_DATA !== 8'hC3) begin errors++; $display("FAIL t6_pdata got=%h exp=c3", P_DATA); end
        checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL t6_partyp_toggle got=%b exp=0", PAR_ERR); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_parity_ok();
        test_parity_err();
        test_stop_err();
        test_start_glitch();
        test_data_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
